lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the core's memory-stage control (MemRead/MemWrite decoded from opcodes 0000011/0100011) and a data memory with a req/ack handshake.
- Freezes the core via stall_o while an access is in flight.
- Generates byte enables for sb/sh/sw.
- Aligns and extends load data for lb/lh/lw/lbu/lhu.
- Reports misaligned, illegal and timed-out accesses.

Parameters:
- DATA_W, 32: data width; only 32 is supported.
- ADDR_W, 8: word-address width of dm_addr_o.
- TIMEOUT, 15: maximum BUS cycles to wait for dm_ack_i before abort, range 1..255.

Ports:
- clk  in  1: single clock; all state changes on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- mem_read_i  in  1: load requested by the current instruction.
- mem_write_i  in  1: store requested by the current instruction.
- funct3_i  in  3: instruction funct3.
- addr_i  in  32: byte address from the ALU.
- wdata_i  in  32: store data (rs2).
- stall_o  out  1: core must hold PC and pipeline registers.
- rdata_o  out  32: extended load result.
- load_wen_o  out  1: one-cycle register-file write enable for a load result.
- err_o  out  1: one-cycle fault pulse.
- err_code_o  out  2: fault code; 00 none, 01 misaligned, 10 timeout, 11 illegal.
- dm_req_o  out  1: memory request.
- dm_we_o  out  1: 1 = write.
- dm_addr_o  out  ADDR_W: word address, addr_i[ADDR_W+1:2].
- dm_wdata_o  out  32: lane-replicated store data.
- dm_be_o  out  4: byte enables.
- dm_ack_i  in  1: memory completion.
- dm_rdata_i  in  32: memory read word.

Behaviour:
- Reset, asynchronous: state=IDLE, timeout counter=0; all registered outputs 0; rdata_o=0.
- States: IDLE, BUS, DONE, FAULT.
- IDLE, no request: stall_o=0; all outputs 0.
- IDLE, request (mem_read_i|mem_write_i):
  - stall_o=1 combinationally in the same cycle.
  - Capture op, funct3, addr and wdata into registers.
  - Legal access -> BUS.
  - Otherwise -> FAULT, with code latched.
- Illegal (code 11): funct3 in {011,110,111}; a store with funct3 >= 011; or both mem_read_i and mem_write_i high.
- Misaligned (code 01): word access with addr[1:0]!=0, or half access with addr[0]!=0. Illegal takes priority over misaligned.
- BUS:
  - dm_req_o=1; dm_we_o, dm_addr_o, dm_wdata_o and dm_be_o are held stable from registers; stall_o=1.
  - On dm_ack_i: latch dm_rdata_i, go DONE. Ack in the first BUS cycle is legal.
  - Counter increments each BUS cycle without ack. Reaching TIMEOUT -> FAULT with code 10; dm_req_o drops on the next cycle.
- DONE, one cycle:
  - stall_o=0; dm_req_o=0.
  - Loads: rdata_o = aligned/extended word; load_wen_o=1.
  - Stores: load_wen_o=0.
  - Next state IDLE. The core advances at the end of DONE, so IDLE always sees a new instruction; no double issue.
- FAULT, one cycle: stall_o=0, err_o=1, err_code_o valid, load_wen_o=0, rdata_o=0, no memory write performed; next state IDLE.
- Store lanes:
  - sb: be = 0001<<addr[1:0]; wdata = byte replicated x4.
  - sh: be = 0011<<(2*addr[1]); wdata = half replicated x2.
  - sw: be = 1111.
- Load lanes:
  - lb/lbu: byte at lane addr[1:0], sign/zero-extended.
  - lh/lhu: half at addr[1], sign/zero-extended.
  - lw: word unchanged.
- dm_ack_i outside BUS, including a late ack after a timeout, is ignored.
- Reset asserted mid-access: dm_req_o drops immediately and the access is abandoned.
- err_code_o holds 00 except during FAULT.

Decomposition:
- Shared package lsu_pkg:
  - state enum lsu_state_t {IDLE,BUS,DONE,FAULT}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Error-code constants ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
- One combinational sub-module, lsu_align: store byte-enable/replication and load extraction/extension. The FSM and timeout counter stay in lsu_sequencer.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, ack after 3 BUS cycles -> dm_addr=4, be=1111, dm_req high 3 cycles, stall high 4 cycles then low 1 cycle (DONE), load_wen_o=0.
- lb addr=0x23, dm_rdata=0x80FF7F01, immediate ack -> rdata_o=0xFFFFFF80, load_wen_o pulses 1 cycle; lbu same access -> 0x00000080.
- lh addr=0x2 on dm_rdata=0x8001AAAA -> rdata_o=0xFFFF8001; sh addr=0x6 wdata=0x1234 -> be=1100, dm_wdata=0x12341234.
- lw addr=0x5 -> no dm_req, FAULT next cycle, err_o=1, err_code=01; funct3=011 load -> err_code=11.
- Load with ack never asserted, TIMEOUT=15 -> dm_req high exactly 15 cycles, err_code=10; ack injected 2 cycles later is ignored and load_wen_o stays 0.
- reset pulled low in BUS cycle 2 -> dm_req_o and stall_o go 0 asynchronously; after release, a new sw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
// Holds the FSM state encoding, funct3 and fault codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE,
        FAULT
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // Illegal outranks misaligned.
    function automatic logic [1:0] classify(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic [1:0] code;
        logic       bad;
        bad = (rd && wr)
            || (f3 == 3'b011)
            || (f3 == 3'b110)
            || (f3 == 3'b111)
            || (wr && (f3 >= 3'b011));
        code = ERR_NONE;
        if (bad) begin
            code = ERR_ILLEGAL;
        end else if ((f3[1:0] == 2'b10) && (lo != 2'b00)) begin
            code = ERR_MISALIGN;
        end else if ((f3[1:0] == 2'b01) && lo[0]) begin
            code = ERR_MISALIGN;
        end
        return code;
    endfunction

endpackage

// File: rtl/lsu_sequencer_align.sv
// Lane steering for the sequencer: store byte enables and
// replication, load byte/half extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        signed_ld;

    // Store side: enables follow access size and low address bits.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign/zero extend.
    always_comb begin
        shifted   = rdata >> {addr_lo, 3'b000};
        lane_b    = shifted[7:0];
        lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        signed_ld = ~funct3[2];
        case (funct3[1:0])
            2'b00:   rdata_ext = {{24{signed_ld & lane_b[7]}}, lane_b};
            2'b01:   rdata_ext = {{16{signed_ld & lane_h[15]}}, lane_h};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer with req/ack data memory port.
// Stalls the core during an access, reports faults and timeouts.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              load_wen_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [31:0]       dm_wdata_o,
    output logic [3:0]        dm_be_o,
    input  logic              dm_ack_i,
    input  logic [31:0]       dm_rdata_i
);

    lsu_state_t        state;
    lsu_state_t        state_nx;
    logic [7:0]        cnt;
    logic              store_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [1:0]        code_q;

    logic              req;
    logic [1:0]        code_in;
    logic              expired;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              unused_addr;

    assign req         = mem_read_i | mem_write_i;
    assign code_in     = classify(mem_read_i, mem_write_i,
                                  funct3_i, addr_i[1:0]);
    assign expired     = (cnt == 8'(TIMEOUT - 1));
    assign unused_addr = ^addr_i[31:ADDR_W+2];

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: decode in IDLE, wait for ack or timeout in BUS.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = (code_in == ERR_NONE) ? BUS : FAULT;
                end
            end
            BUS: begin
                if (dm_ack_i) begin
                    state_nx = DONE;
                end else if (expired) begin
                    state_nx = FAULT;
                end
            end
            DONE:    state_nx = IDLE;
            FAULT:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Access registers, timeout counter and captured read word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            code_q  <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        store_q <= mem_write_i;
                        f3_q    <= funct3_i;
                        addr_q  <= addr_i[ADDR_W+1:0];
                        wdata_q <= wdata_i;
                        code_q  <= code_in;
                    end
                end
                BUS: begin
                    if (dm_ack_i) begin
                        rdata_q <= dm_rdata_i;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (expired) begin
                            code_q <= ERR_TIMEOUT;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Outputs decoded from state; stall also drops during reset.
    always_comb begin
        stall_o    = reset & (((state == IDLE) & req) | (state == BUS));
        dm_req_o   = (state == BUS);
        dm_we_o    = (state == BUS) & store_q;
        dm_addr_o  = '0;
        dm_wdata_o = '0;
        dm_be_o    = '0;
        rdata_o    = '0;
        load_wen_o = 1'b0;
        err_o      = (state == FAULT);
        err_code_o = (state == FAULT) ? code_q : ERR_NONE;
        if (state == BUS) begin
            dm_addr_o = addr_q[ADDR_W+1:2];
            dm_be_o   = store_q ? be : 4'b1111;
            if (store_q) begin
                dm_wdata_o = wdata_rep;
            end
        end
        if ((state == DONE) && !store_q) begin
            rdata_o    = rdata_ext;
            load_wen_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: directed accesses with
// hand-computed bus transactions and completion responses.
module tb_lsu_sequencer;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        load_wen;
    logic        err;
    logic [1:0]  err_code;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    lsu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .stall_o     (stall),
        .rdata_o     (rdata),
        .load_wen_o  (load_wen),
        .err_o       (err),
        .err_code_o  (err_code),
        .dm_req_o    (dm_req),
        .dm_we_o     (dm_we),
        .dm_addr_o   (dm_addr),
        .dm_wdata_o  (dm_wdata),
        .dm_be_o     (dm_be),
        .dm_ack_i    (dm_ack),
        .dm_rdata_i  (dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk_wr;
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        wen;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
        int          reqs;
        int          stalls;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack in BUS cycle ack_at (0 = never).
    int          ack_at = 0;
    int          bcnt = 0;
    logic [31:0] mem_word = '0;
    logic        mem_ack = 1'b0;
    logic        late_ack = 1'b0;
    assign dm_ack   = mem_ack | late_ack;
    assign dm_rdata = mem_ack ? mem_word : 32'hBAD0BAD0;

    always @(negedge clk) begin
        if (dm_req) begin
            bcnt    = bcnt + 1;
            mem_ack = (ack_at != 0) && (bcnt == ack_at);
        end else begin
            bcnt    = 0;
            mem_ack = 1'b0;
        end
    end

    // Monitor: checks bus on req rise, response when stall falls.
    logic  prev_stall = 1'b0;
    logic  prev_req = 1'b0;
    int    reqs = 0;
    int    stalls = 0;
    bus_t  b;
    resp_t r;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
            reqs       = 0;
            stalls     = 0;
        end else begin
            if (dm_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_unexpected: addr %h", dm_addr);
                end else begin
                    b = bus_q.pop_front();
                    chk("dm_we", 32'(dm_we), 32'(b.we));
                    chk("dm_addr", 32'(dm_addr), 32'(b.addr));
                    if (b.chk_wr) begin
                        chk("dm_be", 32'(dm_be), 32'(b.be));
                        chk("dm_wdata", dm_wdata, b.wdata);
                    end
                end
            end
            if (dm_req) reqs++;
            if (stall) stalls++;
            if (prev_stall && !stall) begin
                if (resp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: wen %b err %b",
                             load_wen, err);
                end else begin
                    r = resp_q.pop_front();
                    chk("load_wen", 32'(load_wen), 32'(r.wen));
                    chk("rdata", rdata, r.rdata);
                    chk("err", 32'(err), 32'(r.err));
                    chk("err_code", 32'(err_code), 32'(r.code));
                    chk("req_cycles", 32'(reqs), 32'(r.reqs));
                    chk("stall_cycles", 32'(stalls), 32'(r.stalls));
                end
                reqs   = 0;
                stalls = 0;
            end
            prev_stall = stall;
            prev_req   = dm_req;
        end
    end

    task automatic exp_bus(input logic cw, input logic we,
                           input logic [7:0] a, input logic [3:0] be,
                           input logic [31:0] wd);
        bus_t t;
        t.chk_wr = cw;
        t.we     = we;
        t.addr   = a;
        t.be     = be;
        t.wdata  = wd;
        bus_q.push_back(t);
    endtask

    task automatic exp_resp(input logic wen, input logic [31:0] rd,
                            input logic e, input logic [1:0] code,
                            input int nreq, input int nstall);
        resp_t t;
        t.wen    = wen;
        t.rdata  = rd;
        t.err    = e;
        t.code   = code;
        t.reqs   = nreq;
        t.stalls = nstall;
        resp_q.push_back(t);
    endtask

    // Present one instruction and hold it until stall drops.
    task automatic issue(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ack,
                         input logic [31:0] word);
        bit done;
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        ack_at    = ack;
        mem_word  = word;
        done      = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: addr %h stall %b", a, stall);
        end
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dm_req), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_wen", 32'(load_wen), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);

        // sw, ack in third BUS cycle
        exp_bus(1, 1, 8'h04, 4'b1111, 32'hDEADBEEF);
        exp_resp(0, 32'h0, 0, 2'b00, 3, 4);
        issue(0, 1, F3_W, 32'h10, 32'hDEADBEEF, 3, 32'h0);

        // lb / lbu lane 3
        exp_bus(0, 0, 8'h08, 4'b0, 32'h0);
        exp_resp(1, 32'hFFFFFF80, 0, 2'b00, 1, 2);
        issue(1, 0, F3_B, 32'h23, 32'h0, 1, 32'h80FF7F01);
        exp_bus(0, 0, 8'h08, 4'b0, 32'h0);
        exp_resp(1, 32'h00000080, 0, 2'b00, 1, 2);
        issue(1, 0, F3_BU, 32'h23, 32'h0, 1, 32'h80FF7F01);

        // lb positive byte lane 3
        exp_bus(0, 0, 8'h00, 4'b0, 32'h0);
        exp_resp(1, 32'h0000007F, 0, 2'b00, 1, 2);
        issue(1, 0, F3_B, 32'h3, 32'h0, 1, 32'h7F000000);

        // lh upper half, lhu lower half
        exp_bus(0, 0, 8'h00, 4'b0, 32'h0);
        exp_resp(1, 32'hFFFF8001, 0, 2'b00, 1, 2);
        issue(1, 0, F3_H, 32'h2, 32'h0, 1, 32'h8001AAAA);
        exp_bus(0, 0, 8'h00, 4'b0, 32'h0);
        exp_resp(1, 32'h0000F00D, 0, 2'b00, 1, 2);
        issue(1, 0, F3_HU, 32'h0, 32'h0, 1, 32'h1234F00D);

        // sh upper half, sb lane 1
        exp_bus(1, 1, 8'h01, 4'b1100, 32'h12341234);
        exp_resp(0, 32'h0, 0, 2'b00, 1, 2);
        issue(0, 1, F3_H, 32'h6, 32'h00001234, 1, 32'h0);
        exp_bus(1, 1, 8'h10, 4'b0010, 32'hABABABAB);
        exp_resp(0, 32'h0, 0, 2'b00, 2, 3);
        issue(0, 1, F3_B, 32'h41, 32'h000000AB, 2, 32'h0);

        // lw at top word address
        exp_bus(0, 0, 8'h3F, 4'b0, 32'h0);
        exp_resp(1, 32'hCAFEBABE, 0, 2'b00, 2, 3);
        issue(1, 0, F3_W, 32'hFC, 32'h0, 2, 32'hCAFEBABE);

        // faults: misaligned and illegal
        exp_resp(0, 32'h0, 1, ERR_MISALIGN, 0, 1);
        issue(1, 0, F3_W, 32'h5, 32'h0, 1, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_ILLEGAL, 0, 1);
        issue(1, 0, 3'b011, 32'h0, 32'h0, 1, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_ILLEGAL, 0, 1);
        issue(0, 1, 3'b100, 32'h0, 32'h0, 1, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_ILLEGAL, 0, 1);
        issue(1, 1, F3_W, 32'h0, 32'h0, 1, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_MISALIGN, 0, 1);
        issue(1, 0, F3_H, 32'h1, 32'h0, 1, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_ILLEGAL, 0, 1);
        issue(1, 0, 3'b011, 32'h1, 32'h0, 1, 32'h0);

        // timeout, then a late ack that must be ignored
        exp_bus(0, 0, 8'h02, 4'b0, 32'h0);
        exp_resp(0, 32'h0, 1, ERR_TIMEOUT, 15, 16);
        issue(1, 0, F3_W, 32'h8, 32'h0, 0, 32'h0);
        @(posedge clk);
        #1;
        late_ack = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_wen", 32'(load_wen), 32'd0);
        chk("late_ack_req", 32'(dm_req), 32'd0);
        @(negedge clk);
        chk("late_ack_wen2", 32'(load_wen), 32'd0);

        // reset asserted in BUS cycle 2
        exp_bus(1, 1, 8'h08, 4'b1111, 32'h11223344);
        @(posedge clk);
        #1;
        mem_write = 1'b1;
        funct3    = F3_W;
        addr      = 32'h20;
        wdata     = 32'h11223344;
        ack_at    = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("bus2_req", 32'(dm_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(dm_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        exp_bus(1, 1, 8'h0C, 4'b1111, 32'h55667788);
        exp_resp(0, 32'h0, 0, 2'b00, 1, 2);
        issue(0, 1, F3_W, 32'h30, 32'h55667788, 1, 32'h0);

        repeat (3) @(posedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
